// File: rtl/uart_tx_sched_if.sv
// Byte-source handshake and UART transmitter link for uart_tx_sched.
// slave = scheduler side, master = clients plus transmitter.
interface uart_tx_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_en;
    logic [9:0]        tx_data;
    logic              tx_done;
    logic              tx_busy;
    logic [IDW-1:0]    grant_id;
    logic              active;
    logic              timeout_err;

    modport master (
        output req_valid, req_data, tx_done, tx_busy,
        input  req_ready, tx_en, tx_data, grant_id,
        input  active, timeout_err
    );

    modport slave (
        input  req_valid, req_data, tx_done, tx_busy,
        output req_ready, tx_en, tx_data, grant_id,
        output active, timeout_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte sources.
// Optional macro UART_TX_SCHED_PARITY_EN puts even parity in tx_data[8].
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = 2
) (
    input logic           clk,
    input logic           rst,
    uart_tx_sched_if.slave bus
);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic            tx_en_q, tx_en_d;
    logic [9:0]      tx_data_q, tx_data_d;
    logic            act_q, act_d;
    logic            terr_q, terr_d;

    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic [7:0]      sel_byte;
    logic            par;
    logic            busy_unused;

    // Search starts just past the last grant and wraps around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign sel_byte = bus.req_data[{win, 3'b000} +: 8];

`ifdef UART_TX_SCHED_PARITY_EN
    assign par = ^sel_byte;
`else
    assign par = 1'b1;
`endif

    assign busy_unused = bus.tx_busy;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        wdog_d    = wdog_q;
        ready_d   = '0;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        terr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = SEND;
                    ptr_d     = win;
                    grant_d   = win;
                    ready_d   = NREQ'(1) << win;
                    tx_en_d   = 1'b1;
                    tx_data_d = {1'b1, par, sel_byte};
                    wdog_d    = '0;
                end
            end
            SEND: begin
                // A done on the limit edge still counts as success.
                if (bus.tx_done) begin
                    state_d = GAP;
                    tx_en_d = 1'b0;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    state_d = GAP;
                    tx_en_d = 1'b0;
                    terr_d  = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        act_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(NREQ - 1);
            grant_q   <= '0;
            wdog_q    <= '0;
            ready_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 10'h3FF;
            act_q     <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            wdog_q    <= wdog_d;
            ready_q   <= ready_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            act_q     <= act_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.tx_en       = tx_en_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_q;
    assign bus.active      = act_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: random request sets, a transmitter
// model with chosen Done delays, and a monitor comparing every frame.
module tb_uart_tx_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;
    localparam int NEVER   = -1;
    localparam int RAND    = -2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    uart_tx_sched #(
        .NREQ(NREQ),
        .TIMEOUT(TIMEOUT),
        .IDW(IDW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.tx_busy = bus.tx_en;

    typedef struct {
        int         id;
        logic [9:0] frame;
        int         fall;
        bit         to;
    } exp_t;

    exp_t exp_q[$];
    int   dly_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ptr_m    = NREQ - 1;
    int   spur_cnt = 0;
    bit   in_frame = 1'b0;
    bit   gap      = 1'b0;
    exp_t cur;
    int   cyc      = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endfunction

    // Frame = stop, parity-or-stop, data; even parity means total ones even.
    function automatic logic [9:0] frame_of(logic [7:0] b);
`ifdef UART_TX_SCHED_PARITY_EN
        return {1'b1, 1'($countones(b) % 2), b};
`else
        return {2'b11, b};
`endif
    endfunction

    function automatic int pick_d();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return NEVER;
        if (r == 1) return TIMEOUT - 1;
        if (r == 2) return TIMEOUT - 2;
        return $urandom_range(1, 20);
    endfunction

    // Serve order for a request set: rotate from just past the last winner.
    task automatic plan(input logic [NREQ-1:0] mask, input int dsel);
        logic [NREQ-1:0] m;
        exp_t e;
        int c;
        int d;
        m = mask;
        while (m != 0) begin
            c = 0;
            for (int j = 1; j <= NREQ; j++) begin
                c = (ptr_m + j) % NREQ;
                if (m[c]) break;
            end
            d = (dsel == RAND) ? pick_d() : dsel;
            e.id    = c;
            e.frame = frame_of(bus.req_data[8*c +: 8]);
            e.to    = (d < 0) || (d + 1 > TIMEOUT);
            e.fall  = e.to ? TIMEOUT : d + 1;
            exp_q.push_back(e);
            dly_q.push_back(d);
            ptr_m = c;
            m[c]  = 1'b0;
        end
    endtask

    task automatic round(input logic [NREQ-1:0] mask, input int dsel,
                         input logic [7:0] fb, input bit use_fixed);
        int n;
        for (int i = 0; i < NREQ; i++)
            bus.req_data[8*i +: 8] = use_fixed ? fb : 8'($urandom);
        plan(mask, dsel);
        bus.req_valid = mask;
        n = 0;
        while ((bus.req_valid != 0 || exp_q.size() != 0 ||
                in_frame || gap) && n < 2000) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
            n++;
        end
        chk("round_done", 32'(n < 2000), 1);
        if (n >= 2000) begin
            exp_q.delete();
            dly_q.delete();
            bus.req_valid = '0;
        end
    endtask

    // Transmitter model: pulses Done a chosen number of cycles after tx_en.
    always @(negedge clk) begin : txm
        static int cnt       = NEVER;
        static bit en_prev   = 1'b0;
        static int spur_seen = 0;
        bus.tx_done = 1'b0;
        if (!rst) begin
            cnt     = NEVER;
            en_prev = 1'b0;
        end else begin
            if (bus.tx_en && !en_prev) begin
                if (dly_q.size() > 0) cnt = dly_q.pop_front();
                else cnt = NEVER;
            end
            if (cnt == 0) begin
                bus.tx_done = 1'b1;
                cnt = NEVER;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (spur_cnt != spur_seen) begin
                bus.tx_done = 1'b1;
                spur_seen   = spur_cnt;
            end
            en_prev = bus.tx_en;
        end
    end

    always @(negedge clk) begin : mon
        if (!rst) begin
            in_frame = 1'b0;
            gap      = 1'b0;
        end else if (in_frame) begin
            cyc++;
            chk("ready_one_cycle", 32'(bus.req_ready), 0);
            if (!bus.tx_en) begin
                chk("fall_cycle", cyc, cur.fall);
                chk("timeout_err", 32'(bus.timeout_err), 32'(cur.to));
                chk("active_gap", 32'(bus.active), 1);
                in_frame = 1'b0;
                gap      = 1'b1;
            end else begin
                chk("tx_data_stable", 32'(bus.tx_data), 32'(cur.frame));
                chk("no_early_err", 32'(bus.timeout_err), 0);
            end
        end else begin
            if (gap) begin
                gap = 1'b0;
                if (bus.req_ready == 0)
                    chk("active_fall", 32'(bus.active), 0);
                chk("no_late_err", 32'(bus.timeout_err), 0);
            end
            if (bus.req_ready != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.req_ready), 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("req_ready", 32'(bus.req_ready), 32'(1) << cur.id);
                    chk("grant_id", 32'(bus.grant_id), 32'(cur.id));
                    chk("tx_data", 32'(bus.tx_data), 32'(cur.frame));
                    chk("tx_en_rise", 32'(bus.tx_en), 1);
                    chk("active_rise", 32'(bus.active), 1);
                    cyc      = 0;
                    in_frame = 1'b1;
                end
            end else begin
                chk("idle_tx_en", 32'(bus.tx_en), 0);
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_tx_en", 32'(bus.tx_en), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h3FF);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_active", 32'(bus.active), 0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    endtask

    initial begin : stim
        int n;
        bus.req_valid = '1;
        bus.req_data  = '0;
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals();
        end
        rst = 1'b1;
        round(4'hF, RAND, 8'h00, 1'b0);

        round(4'b0100, 13, 8'hA5, 1'b1);

        round(4'hF, RAND, 8'h00, 1'b0);
        round(4'hF, RAND, 8'h00, 1'b0);

        round(4'b0001, NEVER, 8'h00, 1'b0);
        round(4'b0011, RAND, 8'h00, 1'b0);
        round(4'b1000, TIMEOUT - 1, 8'h00, 1'b0);
        round(4'b0100, TIMEOUT, 8'h00, 1'b0);

        spur_cnt++;
        repeat (4) begin
            @(negedge clk);
            chk("spur_tx_en", 32'(bus.tx_en), 0);
            chk("spur_active", 32'(bus.active), 0);
        end
        round(4'hF, RAND, 8'h00, 1'b0);

        for (int i = 0; i < NREQ; i++)
            bus.req_data[8*i +: 8] = 8'($urandom);
        plan(4'b0100, NEVER);
        bus.req_valid = 4'b0100;
        n = 0;
        while (!bus.tx_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midsend_started", 32'(bus.tx_en), 1);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        exp_q.delete();
        dly_q.delete();
        ptr_m = NREQ - 1;
        @(negedge clk);
        rst = 1'b1;
        round(4'b1010, RAND, 8'h00, 1'b0);

        repeat (20) round(NREQ'($urandom_range(1, 15)), RAND, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : guard
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end
endmodule
